// File: rtl/fpu_io_pkg.sv
// Shared types and constants for the byte-serial FPU front end.
// State encoding doubles as the status-byte state field.
package fpu_io_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_ISSUE  = 3'd3,
    ST_WAIT   = 3'd4,
    ST_DRAIN  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD  = 2'd0,
    OP_SUB  = 2'd1,
    OP_MUL  = 2'd2,
    OP_PASS = 2'd3
  } opcode_t;

  localparam logic [31:0] FPU_QNAN = 32'h7FC0_0000;
  localparam int OPERAND_BYTES = 4;

  localparam int STAT_STATE_LSB = 5;
  localparam int STAT_OVR       = 4;
  localparam int STAT_ERR_CMD   = 3;
  localparam int STAT_ERR_TO    = 2;
  localparam int STAT_CNT_LSB   = 0;

endpackage

// File: rtl/strobe_sync.sv
// N-stage synchroniser for a raw asynchronous strobe pin,
// followed by a single-cycle rising-edge pulse.
module strobe_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic rise
);

  logic [N-1:0] sync;
  logic         last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      last <= 1'b0;
    end else begin
      sync <= {sync[N-2:0], raw};
      last <= sync[N-1];
    end
  end

  assign rise = sync[N-1] & ~last;

endmodule

// File: rtl/fpu_byte_loader.sv
// Byte-serial loader: command + two operands in, start/wait on
// the FPU core with timeout, result drained one byte per read.
module fpu_byte_loader
  import fpu_io_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic [7:0]  in_data,
  input  logic        wr_strobe,
  input  logic        rd_strobe,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        busy,
  output logic [1:0]  core_opcode,
  output logic [31:0] core_op_a,
  output logic [31:0] core_op_b,
  output logic        core_start,
  input  logic        core_done,
  input  logic [31:0] core_result
);

  state_t      state;
  state_t      state_next;
  opcode_t     opcode;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] result;
  logic [1:0]  byte_cnt;
  logic [7:0]  to_cnt;
  logic        ovr;
  logic        err_cmd;
  logic        err_to;
  logic        wr_rise;
  logic        rd_rise;
  logic        wr_edge;
  logic        rd_edge;
  logic        cmd_ok;
  logic        cnt_last;
  logic        timeout;
  logic        late_wr;

  strobe_sync #(.N(SYNC_STAGES)) u_wr_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (wr_strobe),
    .rise  (wr_rise)
  );

  strobe_sync #(.N(SYNC_STAGES)) u_rd_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (rd_strobe),
    .rise  (rd_rise)
  );

  assign wr_edge  = wr_rise & ena;
  assign rd_edge  = rd_rise & ena;
  assign cmd_ok   = (in_data[7:2] == 6'd0);
  assign cnt_last = (byte_cnt == 2'(OPERAND_BYTES - 1));
  assign timeout  = (to_cnt == 8'(TIMEOUT_CYCLES - 1));
  assign late_wr  = wr_edge &
                    ((state == ST_ISSUE) |
                     (state == ST_WAIT) |
                     (state == ST_DRAIN));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:
        if (wr_edge && cmd_ok) state_next = ST_LOAD_A;
      ST_LOAD_A:
        if (wr_edge && cnt_last) state_next = ST_LOAD_B;
      ST_LOAD_B:
        if (wr_edge && cnt_last) state_next = ST_ISSUE;
      ST_ISSUE:
        state_next = ST_WAIT;
      ST_WAIT:
        if (core_done || timeout) state_next = ST_DRAIN;
      ST_DRAIN:
        if (rd_edge && cnt_last) state_next = ST_IDLE;
      default:
        state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode   <= OP_ADD;
      op_a     <= '0;
      op_b     <= '0;
      result   <= '0;
      byte_cnt <= '0;
      to_cnt   <= '0;
      ovr      <= 1'b0;
      err_cmd  <= 1'b0;
      err_to   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (wr_edge && cmd_ok) begin
            opcode   <= opcode_t'(in_data[1:0]);
            err_cmd  <= 1'b0;
            err_to   <= 1'b0;
            ovr      <= 1'b0;
            byte_cnt <= '0;
          end else if (wr_edge) begin
            err_cmd <= 1'b1;
          end
        end
        ST_LOAD_A: begin
          if (wr_edge) begin
            op_a     <= {op_a[23:0], in_data};
            byte_cnt <= byte_cnt + 2'd1;
          end
        end
        ST_LOAD_B: begin
          if (wr_edge) begin
            op_b     <= {op_b[23:0], in_data};
            byte_cnt <= byte_cnt + 2'd1;
          end
        end
        ST_ISSUE: to_cnt <= '0;
        ST_WAIT: begin
          // a done pulse beats a coincident timeout
          if (core_done) begin
            result <= core_result;
          end else if (timeout) begin
            result <= FPU_QNAN;
            err_to <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
        end
        ST_DRAIN: begin
          if (rd_edge) byte_cnt <= byte_cnt + 2'd1;
        end
        default: ;
      endcase
      if (late_wr) ovr <= 1'b1;
    end
  end

  always_comb begin
    out_data = '0;
    if (state == ST_DRAIN) begin
      unique case (byte_cnt)
        2'd0: out_data = result[31:24];
        2'd1: out_data = result[23:16];
        2'd2: out_data = result[15:8];
        2'd3: out_data = result[7:0];
        default: out_data = '0;
      endcase
    end else begin
      out_data[STAT_STATE_LSB +: 3] = state;
      out_data[STAT_OVR]            = ovr;
      out_data[STAT_ERR_CMD]        = err_cmd;
      out_data[STAT_ERR_TO]         = err_to;
      out_data[STAT_CNT_LSB +: 2]   = byte_cnt;
    end
  end

  assign out_valid   = (state == ST_DRAIN);
  assign busy        = (state == ST_ISSUE) | (state == ST_WAIT);
  assign core_start  = (state == ST_ISSUE);
  assign core_opcode = opcode;
  assign core_op_a   = op_a;
  assign core_op_b   = op_b;

endmodule

// File: tb/tb_fpu_byte_loader.sv
// Bench for fpu_byte_loader: directed scenarios plus random
// transactions checked against a transaction-level model.
module tb_fpu_byte_loader;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic [7:0]  in_data;
  logic        wr_strobe;
  logic        rd_strobe;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        busy;
  logic [1:0]  core_opcode;
  logic [31:0] core_op_a;
  logic [31:0] core_op_b;
  logic        core_start;
  logic        core_done;
  logic [31:0] core_result;

  int vec = 0;
  int miss = 0;

  int          core_delay = 5;
  logic [31:0] core_res = '0;
  int          pend = -1;
  int          start_total = 0;
  int          wait_total = 0;

  logic m_ovr = 1'b0;
  logic m_ec  = 1'b0;
  logic m_et  = 1'b0;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_A = 3'd1;
  localparam logic [2:0] S_LOAD_B = 3'd2;

  fpu_byte_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .in_data     (in_data),
    .wr_strobe   (wr_strobe),
    .rd_strobe   (rd_strobe),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .busy        (busy),
    .core_opcode (core_opcode),
    .core_op_a   (core_op_a),
    .core_op_b   (core_op_b),
    .core_start  (core_start),
    .core_done   (core_done),
    .core_result (core_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    core_done   = 1'b0;
    core_result = '0;
  end

  // core model: answers core_delay cycles after start, never if < 0
  always @(negedge clk) begin
    core_done = 1'b0;
    if (busy && !core_start) wait_total++;
    if (core_start) begin
      start_total++;
      pend = core_delay;
    end else if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        core_done   = 1'b1;
        core_result = core_res;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] stat(input logic [2:0] st,
                                      input logic [1:0] c);
    return {st, m_ovr, m_ec, m_et, c};
  endfunction

  task automatic wr(input logic [7:0] b);
    in_data   = b;
    wr_strobe = 1'b1;
    cyc(5);
    wr_strobe = 1'b0;
    cyc(5);
  endtask

  task automatic rd();
    rd_strobe = 1'b1;
    cyc(5);
    rd_strobe = 1'b0;
    cyc(5);
  endtask

  task automatic cmd(input logic [7:0] c);
    wr(c);
    if (c[7:2] == 6'd0) begin
      m_ec  = 1'b0;
      m_et  = 1'b0;
      m_ovr = 1'b0;
    end else begin
      m_ec = 1'b1;
    end
  endtask

  task automatic word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) wr(w[31-8*i -: 8]);
  endtask

  task automatic wait_valid(input int lim);
    int n = 0;
    while (!out_valid && n < lim) begin
      cyc(1);
      n++;
    end
    chk("drain_entry", 32'(out_valid), 32'd1);
  endtask

  task automatic drain(input logic [31:0] r);
    for (int i = 0; i < 4; i++) begin
      chk("drain_byte", 32'(out_data), 32'(r[31-8*i -: 8]));
      rd();
    end
    chk("post_drain", 32'(out_data), 32'(stat(S_IDLE, 2'd0)));
    chk("post_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic txn(input logic [1:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] r,
                     input int d);
    int s0;
    s0         = start_total;
    core_delay = d;
    core_res   = r;
    cmd({6'd0, op});
    word(a);
    word(b);
    wait_valid(400);
    chk("opcode", 32'(core_opcode), 32'(op));
    chk("op_a", core_op_a, a);
    chk("op_b", core_op_b, b);
    chk("start_pulses", 32'(start_total - s0), 32'd1);
    drain(r);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    int s0;
    int w0;
    rst_n     = 1'b0;
    ena       = 1'b1;
    in_data   = '0;
    wr_strobe = 1'b0;
    rd_strobe = 1'b0;
    cyc(3);
    chk("rst_out", 32'(out_data), 32'h00);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_start", 32'(core_start), 32'd0);
    rst_n = 1'b1;
    cyc(2);

    // directed add: 1.0 + 2.0 = 3.0
    core_delay = 5;
    core_res   = 32'h4040_0000;
    s0         = start_total;
    cmd(8'h00);
    chk("add_cmd", 32'(out_data), 32'(stat(S_LOAD_A, 2'd0)));
    wr(8'h3F);
    wr(8'h80);
    chk("add_a_cnt", 32'(out_data), 32'(stat(S_LOAD_A, 2'd2)));
    wr(8'h00);
    wr(8'h00);
    chk("add_to_b", 32'(out_data), 32'(stat(S_LOAD_B, 2'd0)));
    word(32'h4000_0000);
    wait_valid(100);
    chk("add_starts", 32'(start_total - s0), 32'd1);
    chk("add_op_a", core_op_a, 32'h3F80_0000);
    chk("add_op_b", core_op_b, 32'h4000_0000);
    chk("add_opcode", 32'(core_opcode), 32'd0);
    drain(32'h4040_0000);

    // random transactions
    for (int t = 0; t < 6; t++) begin
      a = $urandom;
      b = $urandom;
      r = $urandom;
      txn(2'($urandom_range(0, 3)), a, b, r,
          int'($urandom_range(1, 30)));
    end

    // timeout on mul
    core_delay = -1;
    w0 = wait_total;
    cmd(8'h02);
    word($urandom);
    word($urandom);
    wait_valid(400);
    chk("to_wait_cycles", 32'(wait_total - w0), 32'd255);
    m_et = 1'b1;
    drain(32'h7FC0_0000);

    // bad command keeps IDLE, next good command clears error
    cmd(8'h85);
    chk("bad_cmd", 32'(out_data), 32'(stat(S_IDLE, 2'd0)));
    cmd(8'h01);
    chk("good_cmd", 32'(out_data), 32'(stat(S_LOAD_A, 2'd0)));

    // overrun during WAIT, then simultaneous read+write in DRAIN
    core_delay = 60;
    r          = $urandom;
    core_res   = r;
    a          = $urandom;
    b          = $urandom;
    word(a);
    word(b);
    repeat (3) wr(8'($urandom));
    m_ovr = 1'b1;
    wait_valid(100);
    chk("ovr_op_a", core_op_a, a);
    chk("ovr_op_b", core_op_b, b);
    chk("ovr_opcode", 32'(core_opcode), 32'd1);
    chk("ovr_byte0", 32'(out_data), 32'(r[31:24]));
    in_data   = 8'hA5;
    rd_strobe = 1'b1;
    wr_strobe = 1'b1;
    cyc(5);
    rd_strobe = 1'b0;
    wr_strobe = 1'b0;
    cyc(5);
    chk("sim_byte1", 32'(out_data), 32'(r[23:16]));
    chk("sim_valid", 32'(out_valid), 32'd1);
    rd();
    chk("sim_byte2", 32'(out_data), 32'(r[15:8]));
    rd();
    chk("sim_byte3", 32'(out_data), 32'(r[7:0]));
    rd();
    chk("ovr_status", 32'(out_data), 32'(stat(S_IDLE, 2'd0)));

    // reset in the middle of operand B
    s0 = start_total;
    cmd(8'h00);
    word($urandom);
    wr(8'h12);
    wr(8'h34);
    chk("pre_rst", 32'(out_data), 32'(stat(S_LOAD_B, 2'd2)));
    rst_n = 1'b0;
    cyc(2);
    m_ovr = 1'b0;
    m_ec  = 1'b0;
    m_et  = 1'b0;
    chk("mid_rst_out", 32'(out_data), 32'h00);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    cyc(20);
    chk("mid_rst_nostart", 32'(start_total - s0), 32'd0);
    chk("mid_rst_idle", 32'(out_data), 32'h00);
    txn(2'd2, $urandom, $urandom, $urandom, 7);

    // ena low blocks two writes in LOAD_A
    a          = $urandom;
    b          = $urandom;
    r          = $urandom;
    core_delay = 4;
    core_res   = r;
    cmd(8'h03);
    wr(a[31:24]);
    ena = 1'b0;
    wr(8'hEE);
    wr(8'hDD);
    chk("ena_blocked", 32'(out_data), 32'(stat(S_LOAD_A, 2'd1)));
    ena = 1'b1;
    wr(a[23:16]);
    wr(a[15:8]);
    wr(a[7:0]);
    word(b);
    wait_valid(100);
    chk("ena_op_a", core_op_a, a);
    chk("ena_op_b", core_op_b, b);
    drain(r);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/fpu_byte_loader.md
# fpu_byte_loader

Byte-serial front end for the `tt_um_fpu` top level. It sits between the 8-bit pad buses (`ui_in`/`uio_in`/`uo_out`) and the FPU arithmetic core. It assembles one command byte and two 32-bit IEEE-754 operands from strobed input bytes, issues a single-cycle start to the core, and waits for completion with a timeout. It then returns the 32-bit result one byte per read strobe.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchroniser depth on each raw strobe pin; minimum 2.
- `TIMEOUT_CYCLES`, 255: cycles in WAIT before abort; range 1..255.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ena`  in  1  design selected; while 0, no new strobe edges are accepted.
- `in_data`  in  8  input byte from `ui_in`.
- `wr_strobe`  in  1  raw asynchronous write strobe from `uio_in[0]`.
- `rd_strobe`  in  1  raw asynchronous read strobe from `uio_in[1]`.
- `out_data`  out  8  result byte (DRAIN) or status byte (other states), driven to `uo_out`.
- `out_valid`  out  1  high in DRAIN.
- `busy`  out  1  high in ISSUE and WAIT.
- `core_opcode`  out  2  operation: 0 add, 1 sub, 2 mul, 3 reserved-pass.
- `core_op_a`, `core_op_b`  out  32  operands, held stable from ISSUE until the next command.
- `core_start`  out  1  one-cycle pulse.
- `core_done`  in  1  one-cycle pulse from the core.
- `core_result`  in  32  valid in the cycle `core_done`=1.

## Operation
- Each strobe passes through `SYNC_STAGES` flops plus a rising-edge detector. An edge is accepted in the cycle the detector fires and `ena`=1. `in_data` is sampled in that same cycle; the host keeps it stable across the strobe high phase.
- States: IDLE → LOAD_A → LOAD_B → ISSUE → WAIT → DRAIN → IDLE.
- IDLE: a write edge delivers the command byte.
  - bits[1:0] give the opcode; bits[7:2] must be 0.
  - Nonzero reserved bits: set sticky `err_cmd` and stay in IDLE.
  - Valid command: clear `err_cmd`, `err_to`, `ovr`; go to LOAD_A with the byte counter at 0.
- LOAD_A and LOAD_B: four write edges each, MSB first, shifted into the operand register. The 2-bit counter wraps 3→0 on the state change.
- ISSUE: lasts exactly one cycle with `core_start`=1, then WAIT.
- WAIT: the timeout counter clears on entry and increments each cycle.
  - `core_done`: latch `core_result`, go to DRAIN.
  - Counter reaches `TIMEOUT_CYCLES` with no `core_done`: latch 32'h7FC00000, set `err_to`, go to DRAIN.
  - `core_done` and timeout in the same cycle: `core_done` wins and `err_to` stays clear.
- DRAIN: `out_data` = result byte[idx], MSB first. Each read edge advances idx; the 4th read edge returns to IDLE.
- Write edges in ISSUE, WAIT or DRAIN are ignored and set sticky `ovr`.
- Read edges outside DRAIN are ignored with no flag.
- Simultaneous read and write edges in DRAIN: the read is processed and the write sets `ovr`.
- Status byte (all states except DRAIN): {state[2:0], ovr, err_cmd, err_to, byte_cnt[1:0]}.
- `ena`=0 blocks edge acceptance only. The synchronisers keep running, ISSUE and WAIT still progress, and `core_done` is still captured.

## Timing
- Reset values (asynchronous):
  - state IDLE.
  - All counters, flags, operand and result registers 0.
  - `core_start`=0, `busy`=0, `out_valid`=0.
  - `out_data`=8'h00, which is the IDLE status.
  - Synchroniser flops 0.
- Strobe pin rise to acceptance: `SYNC_STAGES`+1 clock edges. The host keeps each strobe high and low for at least `SYNC_STAGES`+2 cycles.
- Last B byte accepted in cycle N: `core_start`=1 in N+1, `busy`=1 in N+1 through the cycle `core_done` arrives.
- `core_done` in cycle M: `out_valid`=1 and `out_data`=result[31:24] in M+1.
- Read edge accepted in cycle R: next byte on `out_data` in R+1. After the 4th read edge, IDLE status in R+1.
- Asserting `rst_n` in any state returns to IDLE with no `core_start` emitted. A pending `core_done` is then ignored because the state is IDLE.

## Structure
- Shared package `fpu_io_pkg` holds:
  - state enum (3 bits).
  - opcode enum.
  - `FPU_QNAN` = 32'h7FC00000.
  - `OPERAND_BYTES` = 4.
  - status-byte field positions.
- One sub-module: `strobe_sync` (parameterised N-stage synchroniser with rising-edge pulse output), instantiated for the write strobe and for the read strobe.

## Test plan
- Add: command 0x00, A bytes 3F 80 00 00, B bytes 40 00 00 00; core model returns 32'h40400000 after 5 cycles.
  - Required: one `core_start` pulse with `core_op_a`=3F800000 and `core_op_b`=40000000.
  - Four reads return 40 40 00 00, then IDLE.
- Timeout: load a mul (command 0x02) and the core never responds.
  - Required: exactly 255 WAIT cycles, then DRAIN with bytes 7F C0 00 00 and the `err_to` status bit set after drain.
- Bad command 0x85: stays in IDLE, `err_cmd`=1, no state change. A following 0x01 clears `err_cmd` and enters LOAD_A.
- Overrun: three write strobes during WAIT.
  - Required: operands unchanged, `ovr`=1 after drain.
  - Simultaneous read and write in DRAIN advances idx by exactly 1.
- `rst_n` pulsed after 2 B bytes: IDLE, `out_data`=00, no start. A full fresh transaction then succeeds.
- `ena`=0 during 2 write strobes in LOAD_A: counter unchanged. Re-enable and complete the load normally.
